// File: rtl/port0_pkt_arbiter_if.sv
// port0_pkt_arbiter_if: request, mux-monitor, grant and status signals of the Port_0 arbiter.
interface port0_pkt_arbiter_if #(parameter int CNT_W = 32);
    logic             lcm_req, ssm_req, port_ready;
    logic [1:0]       mux_out_data_hdr;
    logic             mux_out_data_wr, mux_out_data_valid_wr;
    logic             lcm_grant, ssm_grant, mux_sel;
    logic [CNT_W-1:0] lcm_pkt_cnt, ssm_pkt_cnt;
    logic             err_timeout, err_proto;

    modport master (
        output lcm_req, ssm_req, port_ready, mux_out_data_hdr, mux_out_data_wr, mux_out_data_valid_wr,
        input  lcm_grant, ssm_grant, mux_sel, lcm_pkt_cnt, ssm_pkt_cnt, err_timeout, err_proto
    );

    modport slave (
        input  lcm_req, ssm_req, port_ready, mux_out_data_hdr, mux_out_data_wr, mux_out_data_valid_wr,
        output lcm_grant, ssm_grant, mux_sel, lcm_pkt_cnt, ssm_pkt_cnt, err_timeout, err_proto
    );
endinterface

// File: rtl/port0_pkt_arbiter.sv
// port0_pkt_arbiter: packet-granular round-robin arbiter sharing Port_0 between LCM and SSM,
// with end-of-packet tracking on the mux output, a per-grant watchdog and packet counters.
module port0_pkt_arbiter #(
    parameter logic [15:0] MAX_PKT_CYCLES = 16'd2048,
    parameter int          CNT_W          = 32
) (
    input logic               clk,
    input logic               rst_n,
    port0_pkt_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GRANT_LCM = 2'd1;
    localparam logic [1:0] GRANT_SSM = 2'd2;
    localparam logic [1:0] GAP       = 2'd3;

    logic [1:0]  state;
    logic [15:0] wdog;
    logic        last_ssm, head_seen;
    logic        is_ssm, head, tail, timeout, win_ssm;

    assign is_ssm  = state == GRANT_SSM;
    assign head    = bus.mux_out_data_wr && bus.mux_out_data_hdr == 2'b01;
    assign tail    = bus.mux_out_data_wr && bus.mux_out_data_hdr == 2'b10 && bus.mux_out_data_valid_wr;
    assign timeout = wdog == MAX_PKT_CYCLES - 16'd1;
    // On a tie the source that was not served last wins
    assign win_ssm = bus.ssm_req && (!bus.lcm_req || !last_ssm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            wdog            <= '0;
            last_ssm        <= 1'b1;
            head_seen       <= 1'b0;
            bus.lcm_grant   <= 1'b0;
            bus.ssm_grant   <= 1'b0;
            bus.mux_sel     <= 1'b0;
            bus.lcm_pkt_cnt <= '0;
            bus.ssm_pkt_cnt <= '0;
            bus.err_timeout <= 1'b0;
            bus.err_proto   <= 1'b0;
        end else begin
            bus.err_timeout <= 1'b0;
            bus.err_proto   <= 1'b0;
            case (state)
                IDLE: if (bus.port_ready && (bus.lcm_req || bus.ssm_req)) begin
                    state         <= win_ssm ? GRANT_SSM : GRANT_LCM;
                    bus.lcm_grant <= !win_ssm;
                    bus.ssm_grant <= win_ssm;
                    bus.mux_sel   <= win_ssm;
                    wdog          <= '0;
                    head_seen     <= 1'b0;
                end
                GRANT_LCM, GRANT_SSM: begin
                    wdog          <= wdog + 16'd1;
                    head_seen     <= head_seen | head;
                    bus.err_proto <= head && head_seen;
                    // A tail in the timeout cycle still counts as a completed packet
                    if (tail || timeout) begin
                        state           <= GAP;
                        bus.lcm_grant   <= 1'b0;
                        bus.ssm_grant   <= 1'b0;
                        last_ssm        <= is_ssm;
                        bus.err_timeout <= !tail;
                        if (tail && is_ssm)  bus.ssm_pkt_cnt <= bus.ssm_pkt_cnt + CNT_W'(1);
                        if (tail && !is_ssm) bus.lcm_pkt_cnt <= bus.lcm_pkt_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
